// File: rtl/fir_mac_pkg.sv
// Shared types, default widths and helpers for the time-multiplexed FIR MAC branch.
package fir_mac_pkg;

  localparam int FIR_DATA_W   = 16;
  localparam int FIR_COEF_W   = 10;
  localparam int FIR_NUM_TAPS = 16;
  localparam int FIR_DECIM    = 2;
  localparam int FIR_PROD_W   = FIR_DATA_W + FIR_COEF_W;
  localparam int FIR_ADDR_W   = $clog2(FIR_NUM_TAPS);
  localparam int FIR_ACC_W    = FIR_PROD_W + FIR_ADDR_W;

  typedef enum logic [1:0] {COLLECT, MAC, DRAIN, OUT} state_t;

  function automatic logic signed [FIR_ACC_W-1:0] sext_acc(input logic signed [FIR_PROD_W-1:0] p);
    return {{(FIR_ACC_W-FIR_PROD_W){p[FIR_PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// Sample-in, coefficient-ROM and result-out signals of one polyphase MAC branch.
interface fir_mac_sequencer_if
  import fir_mac_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int COEF_W = FIR_COEF_W,
  parameter int ADDR_W = FIR_ADDR_W,
  parameter int ACC_W  = FIR_ACC_W
);
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [ADDR_W-1:0]        coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  modport master (
    input  in_data, in_valid, coef_data, out_ready,
    output in_ready, coef_addr, out_data, out_valid, busy
  );

  modport slave (
    output in_data, in_valid, coef_data, out_ready,
    input  in_ready, coef_addr, out_data, out_valid, busy
  );
endinterface

// File: rtl/fir_mac_mul.sv
// Combinational signed sample x coefficient multiplier shared by all taps.
module fir_mac_mul #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 10,
  parameter int PROD_W = 26
) (
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [PROD_W-1:0] prod
);
  assign prod = sample * coef;
endmodule

// File: rtl/fir_mac_sequencer.sv
// Decimating FIR branch: collects DECIM samples, then runs all taps through one
// multiplier (one tap per cycle) and presents the full-precision sum.
module fir_mac_sequencer
  import fir_mac_pkg::*;
#(
  parameter int DATA_W   = FIR_DATA_W,
  parameter int COEF_W   = FIR_COEF_W,
  parameter int PROD_W   = FIR_PROD_W,
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int DECIM    = FIR_DECIM,
  parameter int ACC_W    = FIR_ACC_W
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  fir_mac_sequencer_if.master  bus
);
  localparam int ADDR_W = $clog2(NUM_TAPS);
  localparam int PH_W   = ADDR_W + 1;

  if (PROD_W != DATA_W + COEF_W || NUM_TAPS < 2 || (NUM_TAPS & (NUM_TAPS - 1)) != 0 ||
      DECIM < 1 || DECIM > NUM_TAPS || PROD_W != FIR_PROD_W || ACC_W != FIR_ACC_W) begin : g_bad_cfg
    $error("fir_mac_sequencer: illegal parameter combination");
  end

  state_t                   state, state_nxt;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W-1:0]        tap;
  logic [PH_W-1:0]          phase;
  logic                     drain_cnt;
  logic signed [DATA_W-1:0] dline [NUM_TAPS];
  logic signed [DATA_W-1:0] sample_p1;
  logic signed [PROD_W-1:0] prod_comb;
  logic signed [PROD_W-1:0] prod_p2;
  logic signed [ACC_W-1:0]  acc_p3;
  logic                     vld_p1, vld_p2;
  logic                     accept, last_accept, last_tap;

  assign accept      = (state == COLLECT) && bus.in_valid;
  assign last_accept = accept && (phase == PH_W'(DECIM - 1));
  assign last_tap    = (tap == ADDR_W'(NUM_TAPS - 1));

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) state <= COLLECT;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      COLLECT: if (last_accept)   state_nxt = MAC;
      MAC:     if (last_tap)      state_nxt = DRAIN;
      DRAIN:   if (drain_cnt)     state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = COLLECT;
      default:                    state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      COLLECT:    bus.in_ready = 1'b1;
      MAC, DRAIN: bus.busy     = 1'b1;
      OUT: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.coef_addr = tap;
  assign bus.out_data  = acc_p3;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wr_ptr    <= '0;
      phase     <= '0;
      tap       <= '0;
      drain_cnt <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        phase  <= last_accept ? '0 : phase + 1'b1;
      end
      tap       <= (state == MAC) ? tap + 1'b1 : '0;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
      vld_p1    <= (state == MAC);
      vld_p2    <= vld_p1;
    end
  end

  // The delay line is cleared on reset so a restarted branch sees silence, not stale history
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) dline[i] <= '0;
    end else if (accept) begin
      dline[wr_ptr] <= bus.in_data;
    end
  end

  // Stage 1: newest-first sample read, aligned with the ROM's one-cycle coefficient latency
  always_ff @(posedge ap_clk) begin
    sample_p1 <= dline[wr_ptr - 1'b1 - tap];
  end

  fir_mac_mul #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .PROD_W (PROD_W)
  ) u_mul (
    .sample (sample_p1),
    .coef   (bus.coef_data),
    .prod   (prod_comb)
  );

  // Stage 2: registered product
  always_ff @(posedge ap_clk) begin
    prod_p2 <= prod_comb;
  end

  // Stage 3: accumulate; cleared when the last sample of a decimation group arrives
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n || last_accept) acc_p3 <= '0;
    else if (vld_p2)              acc_p3 <= acc_p3 + sext_acc(prod_p2);
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed and randomized bench for fir_mac_sequencer against a convolution-level reference model.
module tb_fir_mac_sequencer;
  import fir_mac_pkg::*;

  localparam int NT  = FIR_NUM_TAPS;
  localparam int DEC = FIR_DECIM;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  int   cyc      = 0;

  fir_mac_sequencer_if bus ();

  fir_mac_sequencer dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  logic signed [FIR_COEF_W-1:0] rom [NT];
  always @(posedge ap_clk) bus.coef_data <= rom[bus.coef_addr];

  int     hist[$];
  longint exp_q[$];
  int     n_acc    = 0;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     last_t   = 0;
  longint last_out = 0;

  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < NT; k++) begin
      if (hist.size() - 1 - k >= 0)
        s += longint'(rom[k]) * longint'(hist[hist.size() - 1 - k]);
    end
    return s;
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    n_acc = 0;
  endtask

  task automatic push_model(input int s);
    hist.push_back(s);
    n_acc++;
    if (n_acc % DEC == 0) exp_q.push_back(model_out());
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int s);
    int n = 0;
    @(negedge ap_clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(s);
    while (!bus.in_ready && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    check("send_in_ready", bus.in_ready, 1);
    last_t = cyc;
    @(posedge ap_clk);
    push_model(s);
  endtask

  task automatic idle();
    @(negedge ap_clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic get_out(input string tag);
    int     n = 0;
    longint e;
    @(negedge ap_clk);
    while (!bus.out_valid && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    check({tag, "_valid"}, bus.out_valid, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    last_out = longint'(bus.out_data);
    check(tag, bus.out_data, e);
    @(posedge ap_clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  bus.in_ready,  1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data,  0);
    check({tag, "_coef_addr"}, bus.coef_addr, 0);
    check({tag, "_busy"},      bus.busy,      0);
  endtask

  initial begin
    int     n;
    int     t0;
    longint e;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < NT; k++) rom[k] = 10'(k + 1);

    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_reset_values("por");

    // impulse response, one decimated phase per output
    send(1); send(0); idle(); get_out("impulse0");
    check("impulse0_const", last_out, 2);
    send(0); send(0); idle(); get_out("impulse1");
    check("impulse1_const", last_out, 4);

    // latency with in_valid held high throughout
    send(11); send(-7); t0 = last_t;
    @(negedge ap_clk);
    bus.in_data = 16'(5);
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge ap_clk); n++; end
    check("lat_out_valid_cycle", cyc - t0, 19);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    check("lat_out_data", bus.out_data, e);
    n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge ap_clk); n++; end
    check("lat_in_ready_cycle", cyc - t0, 20);
    @(posedge ap_clk);
    push_model(5);
    send(9); idle(); get_out("lat_next");

    // worst-case magnitude
    for (int k = 0; k < NT; k++) rom[k] = -10'sd512;
    for (int p = 0; p < NT / DEC; p++) begin
      for (int d = 0; d < DEC; d++) send(-32768);
      idle(); get_out("wc_neg");
    end
    check("wc_neg_const", last_out, 268435456);
    for (int p = 0; p < NT / DEC; p++) begin
      for (int d = 0; d < DEC; d++) send(32767);
      idle(); get_out("wc_pos");
    end
    check("wc_pos_const", last_out, -268427264);

    // backpressure in OUT; in_valid pulses there must be ignored
    for (int k = 0; k < NT; k++) rom[k] = 10'($urandom_range(0, 1023));
    @(negedge ap_clk);
    bus.out_ready = 1'b0;
    send(1234); send(-4321); idle();
    n = 0;
    while (!bus.out_valid && n < 100) begin @(negedge ap_clk); n++; end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data",  bus.out_data,  e);
      check("bp_in_ready",  bus.in_ready,  0);
      bus.in_valid = i[0];
      bus.in_data  = 16'(1000 + i);
      @(negedge ap_clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge ap_clk);
    send(77); send(-88); idle(); get_out("bp_after");

    // reset in the middle of MAC at tap 7
    send(3000); send(-2000); idle();
    n = 0;
    while (bus.coef_addr != 4'd7 && n < 100) begin @(negedge ap_clk); n++; end
    check("rst_reach_k7", bus.coef_addr, 7);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    model_reset();
    check_reset_values("mid_mac_rst");
    send(500); send(-600); idle(); get_out("post_rst0");
    send(700); send(800); idle(); get_out("post_rst1");

    // ramp across the write-pointer wrap
    for (int s = 1; s <= 40; s++) begin
      send(s);
      if (s % DEC == 0) begin idle(); get_out("ramp"); end
    end

    // random samples and coefficients
    for (int k = 0; k < NT; k++) rom[k] = 10'($urandom_range(0, 1023));
    for (int p = 0; p < 12; p++) begin
      for (int d = 0; d < DEC; d++) send(int'($urandom_range(0, 65535)) - 32768);
      idle(); get_out("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Time-multiplexed MAC controller for one polyphase branch of the multirate FIR filterbank. It shares a single signed 16×10 multiplier across all taps of a decimating FIR. The block buffers input samples in a circular delay line and fetches coefficients from an external ROM, issuing one tap per cycle. It accumulates the result and hands one full-precision output per DECIM accepted inputs to the downstream stage.

## Interface
- DATA_W, 16, input sample width (signed)
- COEF_W, 10, coefficient width (signed)
- PROD_W, 26, product width; must equal DATA_W+COEF_W
- NUM_TAPS, 16, filter length; power of two, ≥2
- DECIM, 2, decimation factor, 1..NUM_TAPS
- ACC_W, 30, accumulator/output width; PROD_W+log2(NUM_TAPS)
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst_n  in  1  reset; synchronous and active-low
- in_data  in  DATA_W  signed sample
- in_valid  in  1  sample valid
- in_ready  out  1  block accepts sample this cycle
- coef_addr  out  log2(NUM_TAPS)  coefficient ROM address
- coef_data  in  COEF_W  signed coefficient, valid one cycle after coef_addr
- out_data  out  ACC_W  signed filter output
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts output
- busy  out  1  high in MAC, DRAIN, OUT

## Operation
- States: COLLECT, MAC, DRAIN, OUT. Reset → COLLECT.
- Reset values: in_ready=1 after reset release, out_valid=0, out_data=0, coef_addr=0, busy=0. Delay line, wr_ptr, phase counter, tap counter and accumulator all cleared.
- COLLECT: in_ready=1. On in_valid&&in_ready, write in_data to buf[wr_ptr] and set wr_ptr=(wr_ptr+1) mod NUM_TAPS, with wrap to 0. Increment phase. On the DECIM-th accept, phase←0, go to MAC, clear the accumulator.
- MAC: in_ready=0. The tap counter k runs 0..NUM_TAPS-1, one per cycle. coef_addr=k. The sample register loads buf[(wr_ptr-1-k) mod NUM_TAPS], so k=0 is the newest sample. After k=NUM_TAPS-1, go to DRAIN.
- Pipeline: stage 1 is address plus sample read. Stage 2 is coef_data × sample_q in the multiplier, registered as prod_q. Stage 3 is acc ← acc + sign-extended prod_q. A prod_valid pipeline bit gates the accumulate.
- DRAIN: 2 cycles to flush stages 2–3, then go to OUT.
- OUT: out_valid=1 and out_data=acc, held stable until out_ready. On out_valid&&out_ready, go to COLLECT. out_valid drops the next cycle and in_ready rises the same cycle.
- Arithmetic: full precision with no rounding or saturation. ACC_W is sized so that NUM_TAPS worst-case products (−2^15·−2^9) cannot overflow.
- in_valid while in_ready=0 is ignored. The sample is not captured, and upstream must hold it.
- Reset during any state: all of the above return to reset values on the next edge. A partial sum is discarded, and the delay line is zeroed.

## Timing
- Accept of the DECIM-th sample in cycle t: MAC occupies t+1..t+NUM_TAPS, DRAIN occupies t+NUM_TAPS+1..t+NUM_TAPS+2, and out_valid is first high in cycle t+NUM_TAPS+3 (19 for defaults).
- Minimum period per output is DECIM + NUM_TAPS + 3 cycles, with out_ready held high.
- coef_addr is registered and changes only in MAC, holding 0 otherwise. The ROM must have exactly 1-cycle read latency.
- The multiplier is combinational, and its output is registered in this block.

## Structure
- Package fir_mac_pkg holds the state enum (COLLECT, MAC, DRAIN, OUT), the width localparams (PROD_W, ACC_W, ADDR_W=$clog2(NUM_TAPS)), and the ACC_W sign-extension function.
- Sub-module fir_mac_mul is a combinational signed DATA_W×COEF_W→PROD_W multiplier, instantiated once.
- Elaboration check: PROD_W==DATA_W+COEF_W, NUM_TAPS is a power of two, and 1≤DECIM≤NUM_TAPS.

## Test plan
- Impulse: ROM coef[k]=k+1, feed 1,0 then 0,0, out_ready=1. Outputs are 2 then 4, with the impulse shifting one decimated phase per output.
- Latency: assert in_valid continuously. The 2nd accept is cycle t, out_valid rises in cycle t+19, and the next in_ready rise is cycle t+20.
- Worst-case magnitude: all samples −32768 and all coefs −512, after 16 accepts. out_data is 268435456 with no wrap. Then all samples +32767 with coefs −512 gives −268427264.
- Backpressure: hold out_ready=0 for 10 cycles in OUT. out_data stays stable, in_ready=0, and in_valid pulses are not captured (verify by the next output).
- Reset mid-MAC: drop ap_rst_n for 1 cycle at k=7. The next cycle shows all reset values. The following outputs match a model with a zeroed delay line.
- Wrap-around: stream 40 samples (ramp 1..40). Every output matches a golden model across wr_ptr wrap from 15 to 0.
